// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: computes the actual direction, registers a
// one-cycle redirect on a mispredict, and owns the 2-bit BHT and perf counters.
module branch_resolve #(
    parameter int         WIDTH    = 32,
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       funct3,
    input  logic             lessthan,
    input  logic             equalto,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_pred_taken,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             illegal_branch,
    output logic [15:0]      branch_count,
    output logic [15:0]      mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                resolve;
    logic                cond_resolve;
    logic                slt;
    logic                branch_taken;
    logic                bad_funct3;
    logic                taken;
    logic                mispredict;
    logic                unused_pc_bits;

    assign rd_idx        = if_pc[IDX_BITS+1:2];
    assign wr_idx        = ex_pc[IDX_BITS+1:2];
    assign if_pred_taken = bht[rd_idx][1];
    assign unused_pc_bits = ^{if_pc[WIDTH-1:IDX_BITS+2], if_pc[1:0]};

    // An instruction in EX while a redirect is out is wrong-path.
    assign resolve      = ex_valid & ~stall & ~redirect_valid & (ex_branch | ex_jump);
    assign cond_resolve = resolve & ex_branch & ~ex_jump;

    assign slt = (a_sign != b_sign) ? a_sign : lessthan;

    always_comb begin
        branch_taken = 1'b0;
        bad_funct3   = 1'b0;
        case (funct3)
            3'b000:  branch_taken = equalto;
            3'b001:  branch_taken = ~equalto;
            3'b100:  branch_taken = slt;
            3'b101:  branch_taken = ~slt;
            3'b110:  branch_taken = lessthan;
            3'b111:  branch_taken = ~lessthan;
            default: bad_funct3   = 1'b1;
        endcase
    end

    assign taken      = ex_jump ? 1'b1 : branch_taken;
    assign mispredict = taken != ex_pred_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_branch <= 1'b0;
        end else begin
            redirect_valid <= resolve & mispredict;
            illegal_branch <= cond_resolve & bad_funct3;
            if (resolve && mispredict)
                redirect_pc <= taken ? ex_target : ex_pc + WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                bht[i] <= CNT_INIT;
        end else if (cond_resolve) begin
            if (taken && bht[wr_idx] != 2'b11)
                bht[wr_idx] <= bht[wr_idx] + 2'b01;
            else if (!taken && bht[wr_idx] != 2'b00)
                bht[wr_idx] <= bht[wr_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (cond_resolve && branch_count != 16'hFFFF)
                branch_count <= branch_count + 16'd1;
            if (resolve && mispredict && mispredict_count != 16'hFFFF)
                mispredict_count <= mispredict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, stall, ex_branch, ex_jump;
    logic [2:0]  funct3;
    logic        lessthan, equalto, a_sign, b_sign;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_branch;
    logic [15:0] branch_count, mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_resolve #(.WIDTH(32), .IDX_BITS(4), .CNT_INIT(2'b01)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .stall(stall), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .funct3(funct3), .lessthan(lessthan), .equalto(equalto),
        .a_sign(a_sign), .b_sign(b_sign), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .illegal_branch(illegal_branch),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        stall    = 1'b0;
        ex_jump  = 1'b0;
        ex_branch = 1'b0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic eq, input logic lt,
                          input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0;
        funct3 = f3; equalto = eq; lessthan = lt;
        ex_pred_taken = pred; ex_pc = pc; ex_target = tgt;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    task automatic outs(input string tag, input logic rv, input logic [31:0] rpc,
                        input logic ill, input logic [15:0] bc, input logic [15:0] mc);
        check({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        if (rv) check({tag, ".rpc"}, redirect_pc, rpc);
        check({tag, ".ill"}, {31'd0, illegal_branch}, {31'd0, ill});
        check({tag, ".bc"}, {16'd0, branch_count}, {16'd0, bc});
        check({tag, ".mc"}, {16'd0, mispredict_count}, {16'd0, mc});
    endtask

    initial begin
        reset = 1'b0; if_pc = '0; idle();
        funct3 = 3'b000; lessthan = 0; equalto = 0; a_sign = 0; b_sign = 0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 0;
        tick();
        reset = 1'b1;
        tick();

        // Reset state: every entry weakly not-taken
        for (int i = 0; i < 16; i++) pred_at("rst_pred", 32'(i * 4), 1'b0);
        outs("rst", 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);
        check("rst_rpc", redirect_pc, 32'h0);

        // blt with a=-1, b=1: signed taken, predicted not-taken
        a_sign = 1'b1; b_sign = 1'b0;
        branch(3'b100, 1'b0, 1'b0, 1'b0, 32'h200, 32'h300);
        tick();
        outs("blt", 1'b1, 32'h300, 1'b0, 16'd1, 16'd1);
        idle(); tick();
        check("blt_clear", {31'd0, redirect_valid}, 32'd0);

        // bltu same operands: not taken, correctly predicted
        branch(3'b110, 1'b0, 1'b0, 1'b0, 32'h204, 32'h400);
        tick();
        outs("bltu", 1'b0, 32'h0, 1'b0, 16'd2, 16'd1);
        idle(); a_sign = 0; tick();

        // Predicted-taken miss: fall-through target
        do_reset();
        branch(3'b000, 1'b0, 1'b0, 1'b1, 32'h100, 32'h800);
        tick();
        outs("beq_miss", 1'b1, 32'h104, 1'b0, 16'd1, 16'd1);
        idle(); tick();

        // BHT saturation at PC 0x40 (index 0)
        do_reset();
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 32'h80);
        pred_at("bypass_old", 32'h40, 1'b0);
        tick(); idle(); tick();
        pred_at("sat_t1", 32'h40, 1'b1);
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 32'h80); tick(); idle(); tick();
        pred_at("sat_t2", 32'h40, 1'b1);
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 32'h80); tick(); idle(); tick();
        pred_at("sat_t3", 32'h40, 1'b1);
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 32'h80); tick(); idle(); tick();
        pred_at("sat_t4", 32'h40, 1'b1);
        branch(3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h80); tick(); idle(); tick();
        pred_at("sat_n1", 32'h40, 1'b1);
        branch(3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h80); tick(); idle(); tick();
        pred_at("sat_n2", 32'h40, 1'b0);
        branch(3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h80); tick(); idle(); tick();
        pred_at("sat_n3", 32'h40, 1'b0);
        pred_at("sat_other", 32'h44, 1'b0);
        outs("sat", 1'b0, 32'h0, 1'b0, 16'd7, 16'd4);

        // Idx 0 now 00: one taken makes 01, then idx 1 must be untouched by wrong path
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h80, 32'h500);
        tick();
        outs("wp_first", 1'b1, 32'h500, 1'b0, 16'd8, 16'd5);
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h84, 32'h600);
        tick();
        outs("wp_second", 1'b0, 32'h0, 1'b0, 16'd8, 16'd5);
        pred_at("wp_bht", 32'h84, 1'b0);

        // Stalled branch is ignored
        stall = 1'b1;
        tick();
        outs("stall", 1'b0, 32'h0, 1'b0, 16'd8, 16'd5);
        pred_at("stall_bht", 32'h84, 1'b0);

        // Registered redirect still shows while stalled
        stall = 1'b0;
        tick();
        stall = 1'b1;
        outs("stall_rv", 1'b1, 32'h600, 1'b0, 16'd9, 16'd6);
        tick();
        check("stall_rv_drop", {31'd0, redirect_valid}, 32'd0);
        pred_at("stall_bht2", 32'h84, 1'b1);
        idle(); tick();

        // Illegal funct3: not taken, one-cycle pulse
        branch(3'b010, 1'b1, 1'b1, 1'b0, 32'h88, 32'h700);
        tick();
        outs("ill010", 1'b0, 32'h0, 1'b1, 16'd10, 16'd6);
        idle(); tick();
        check("ill_pulse", {31'd0, illegal_branch}, 32'd0);
        branch(3'b011, 1'b1, 1'b0, 1'b1, 32'h8C, 32'h700);
        tick();
        outs("ill011", 1'b1, 32'h90, 1'b1, 16'd11, 16'd7);
        idle(); tick();

        // Jump: always taken, no BHT, not a branch count
        ex_valid = 1'b1; ex_jump = 1'b1; ex_branch = 1'b0;
        ex_pred_taken = 1'b0; ex_pc = 32'h300; ex_target = 32'h1000;
        tick();
        outs("jump", 1'b1, 32'h1000, 1'b0, 16'd11, 16'd8);
        idle(); tick();
        pred_at("jump_bht", 32'h300, 1'b0);
        ex_valid = 1'b1; ex_jump = 1'b1; ex_pred_taken = 1'b1;
        tick();
        outs("jump_hit", 1'b0, 32'h0, 1'b0, 16'd11, 16'd8);
        idle(); tick();

        // Fall-through wraps past the top of the address space
        branch(3'b001, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h10);
        tick();
        outs("wrap", 1'b1, 32'h0, 1'b0, 16'd12, 16'd9);
        idle(); tick();

        // Back-to-back correct resolves drive branch_count to saturation
        branch(3'b010, 1'b0, 1'b0, 1'b0, 32'h88, 32'h0);
        for (int i = 0; i < 65536; i++) tick();
        outs("bc_sat", 1'b0, 32'h0, 1'b1, 16'hFFFF, 16'd9);
        tick();
        check("bc_hold", {16'd0, branch_count}, 32'h0000_FFFF);
        idle(); tick();

        // Reset while a redirect is showing
        branch(3'b000, 1'b1, 1'b0, 1'b0, 32'h44, 32'h900);
        tick();
        idle();
        check("mid_rv_pre", {31'd0, redirect_valid}, 32'd1);
        reset = 1'b0;
        #1;
        outs("mid_rst", 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);
        pred_at("mid_rst_bht", 32'h44, 1'b0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the pipelined RV32I core. It consumes the unsigned `lessthan`/`equalto` flags from the EX-stage comparator, converts them to signed results where `funct3` requires, and decides the actual branch direction. It checks that outcome against the fetch-stage prediction and issues a registered one-cycle redirect/flush on a mispredict. It also owns the 2-bit saturating branch history table (BHT) that produces fetch-stage predictions, and keeps saturating performance counters.

## Interface
- `WIDTH`, 32: PC and operand width.
- `IDX_BITS`, 4: BHT index width; the BHT has 2^IDX_BITS entries.
- `CNT_INIT`, 2'b01: BHT counter reset value (weakly not-taken).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_pc`  in  WIDTH  fetch PC used for the prediction lookup.
- `if_pred_taken`  out  1  combinational prediction: MSB of `BHT[if_pc[IDX_BITS+1:2]]`.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `stall`  in  1  pipeline stall; EX inputs are ignored while high.
- `ex_branch`  in  1  conditional branch in EX.
- `ex_jump`  in  1  JAL/JALR in EX.
- `funct3`  in  3  branch type.
- `lessthan`  in  1  comparator unsigned a<b.
- `equalto`  in  1  comparator a==b.
- `a_sign`  in  1  operand a bit WIDTH-1.
- `b_sign`  in  1  operand b bit WIDTH-1.
- `ex_pc`  in  WIDTH  PC of the instruction in EX.
- `ex_target`  in  WIDTH  computed branch/jump target.
- `ex_pred_taken`  in  1  prediction carried down the pipeline with the instruction.
- `redirect_valid`  out  1  registered; fetch must load `redirect_pc`, and IF/ID/EX must be flushed.
- `redirect_pc`  out  WIDTH  registered correct next PC.
- `illegal_branch`  out  1  registered; set for one cycle when a branch with `funct3` 010 or 011 resolves.
- `branch_count`  out  16  number of resolved conditional branches; saturates at 16'hFFFF.
- `mispredict_count`  out  16  number of mispredicted conditional branches plus jumps; saturates at 16'hFFFF.

## Operation
- Resolve event is `ex_valid & ~stall & ~redirect_valid & (ex_branch | ex_jump)`. An EX instruction in the cycle `redirect_valid`=1 is wrong-path and is fully ignored.
- Signed less-than is `slt = (a_sign != b_sign) ? a_sign : lessthan`.
- Actual direction (`taken`) by `funct3`:
  - 000 beq = `equalto`; 001 bne = `~equalto`.
  - 100 blt = `slt`; 101 bge = `~slt`.
  - 110 bltu = `lessthan`; 111 bgeu = `~lessthan`.
  - 010/011: not taken, and `illegal_branch` pulses.
- Jump: `taken`=1. A jump never reads or writes the BHT.
- Mispredict is `taken != ex_pred_taken`.
  - Predicted not-taken, actually taken: `redirect_pc` = `ex_target`.
  - Predicted taken, actually not taken: `redirect_pc` = `ex_pc + 4` (mod 2^WIDTH).
- BHT update on a conditional-branch resolve, at index `ex_pc[IDX_BITS+1:2]`:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
- Counters:
  - `branch_count` increments on each conditional-branch resolve.
  - `mispredict_count` increments on each mispredicted resolve.
  - Both hold at 16'hFFFF.

## Timing
- Reset (asynchronous, `reset`=0) sets:
  - every BHT entry to `CNT_INIT`;
  - `redirect_valid`=0, `redirect_pc`=0, `illegal_branch`=0;
  - both counters to 0.
- Resolve in cycle N:
  - BHT and counters update at the end of N.
  - `redirect_valid`/`redirect_pc`/`illegal_branch` are visible in N+1 for exactly one cycle.
- Latency is 1 cycle, independent of `stall`. A redirect already registered still asserts during a stall.
- `if_pred_taken` is combinational. When the BHT write and the read hit the same index in the same cycle, the read returns the pre-update value.
- Back-to-back resolves are possible in N and N+1 only if N did not mispredict. After a redirect, the next resolve can occur at N+2 at the earliest.
- Reset asserted mid-redirect clears `redirect_valid` immediately. No partial BHT update persists.

## Test plan
- **Reset:** reset; release. All BHT predictions read 0, `redirect_valid`=0, counters 0.
- **Signed vs unsigned:** a=0xFFFFFFFF, b=1, so `lessthan`=0, `a_sign`=1, `b_sign`=0.
  - blt, predicted 0: taken. Next cycle `redirect_valid`=1, `redirect_pc`=`ex_target`.
  - bltu, predicted 0: no redirect.
- **Predicted-taken miss:** beq, `equalto`=0, `ex_pred_taken`=1, `ex_pc`=0x100. Next cycle `redirect_pc`=0x104, `mispredict_count`=1.
- **BHT saturation:** the same PC 0x40 resolves taken 4 times. Its counter goes 01→10→11→11, and `if_pred_taken` at 0x40 is 1 after the first update. Then 3 not-taken resolves bring it back to 00.
- **Wrong-path and stall:**
  - In the cycle after a mispredict, drive a second taken branch with `ex_valid`=1. Required: no BHT or counter change and no second redirect.
  - With `stall`=1 and a branch present: no update.
- **Illegal and saturation:**
  - `funct3`=010: `illegal_branch` pulses for 1 cycle and the branch is not taken.
  - Preload `branch_count` near 16'hFFFF by 65,536 resolves: it holds at 16'hFFFF.
